// File: rtl/wb_pkg.sv
// Shared types for the register-file write-side front end.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency sources, the hazard unit and the write arbiter.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_wd;

  logic                  ll_valid;
  logic                  ll_ready;
  logic [REG_ADDR_W-1:0] ll_rd;
  logic [XLEN-1:0]       ll_wd;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_a3;
  logic [XLEN-1:0]       rf_wd;

  logic [REG_ADDR_W-1:0] q_rs1;
  logic [REG_ADDR_W-1:0] q_rs2;
  logic [REG_ADDR_W-1:0] q_rd;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic                  rd_pending;
  logic                  starve_stall;

  modport master (
    output pipe_we, pipe_rd, pipe_wd,
    output ll_valid, ll_rd, ll_wd,
    output q_rs1, q_rs2, q_rd,
    input  ll_ready, rf_we, rf_a3, rf_wd,
    input  rs1_pending, rs2_pending, rd_pending, starve_stall
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd,
    input  ll_valid, ll_rd, ll_wd,
    input  q_rs1, q_rs2, q_rd,
    output ll_ready, rf_we, rf_a3, rf_wd,
    output rs1_pending, rs2_pending, rd_pending, starve_stall
  );

endinterface

// File: rtl/wb_queue.sv
// FIFO of pending long-latency writebacks with destination-register match queries.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  wb_entry_t             push_data,
  input  logic                  pop,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  match_rs1,
  output logic                  match_rs2,
  output logic                  match_rd,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;

  // Push lands after the pop clear so a same-slot update (never expected) keeps the new entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      if (push) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_data;
    end
  end

  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
    match_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        if (q_rs1 != '0 && mem[i].rd == q_rs1) match_rs1 = 1'b1;
        if (q_rs2 != '0 && mem[i].rd == q_rs2) match_rs2 = 1'b1;
        if (q_rd  != '0 && mem[i].rd == q_rd)  match_rd  = 1'b1;
      end
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port arbiter: pipeline writeback has priority, queued long-latency results fill idle slots.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 resetn,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          pipe_eff;
  logic          ready;
  logic          push;
  logic          pop;
  wb_entry_t     head;
  wb_entry_t     push_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [SW-1:0] starve_cnt;

  assign pipe_eff  = bus.pipe_we && (bus.pipe_rd != '0);
  assign ready     = resetn && !full;
  assign push      = bus.ll_valid && ready && (bus.ll_rd != '0);
  assign pop       = !pipe_eff && !empty;
  assign push_data = '{rd: bus.ll_rd, wd: bus.ll_wd};

  wb_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .q_rs1     (bus.q_rs1),
    .q_rs2     (bus.q_rs2),
    .q_rd      (bus.q_rd),
    .match_rs1 (bus.rs1_pending),
    .match_rs2 (bus.rs2_pending),
    .match_rd  (bus.rd_pending),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Outputs are forced quiet while reset is held, even if the pipeline is still driving.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    if (resetn) begin
      if (pipe_eff) begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = bus.pipe_rd;
        bus.rf_wd = bus.pipe_wd;
      end else if (!empty) begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = head.rd;
        bus.rf_wd = head.wd;
      end
    end
  end

  // Counts consecutive cycles the queue waited behind the pipeline; saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (pop || count == '0) begin
      starve_cnt <= '0;
    end else if (pipe_eff && starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.ll_ready     = ready;
  assign bus.starve_stall = (starve_cnt == SW'(STARVE_LIMIT));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end of the 32x32 register file.
- Merges the in-order pipeline writeback with a long-latency writeback source (loads, divider) that uses a valid/ready handshake and can return results late.
- Buffers long-latency results in a small queue and drives the single register-file write port (we/A3/wd).
- Exposes pending-register flags so the hazard unit can stall RAW/WAW on queued destinations.

Parameters:
- QUEUE_DEPTH, 2, number of long-latency entries buffered; power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty queue may be blocked by pipeline writes before starve_stall asserts; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pipe_we  in  1  pipeline writeback valid; no backpressure.
- pipe_rd  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline writeback data.
- ll_valid  in  1  long-latency result valid.
- ll_ready  out  1  long-latency result accepted when ll_valid and ll_ready are both high.
- ll_rd  in  5  long-latency destination register.
- ll_wd  in  32  long-latency result data.
- rf_we  out  1  register-file write enable.
- rf_a3  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- q_rs1  in  5  query address 1.
- q_rs2  in  5  query address 2.
- q_rd  in  5  query address 3.
- rs1_pending  out  1  q_rs1 is nonzero and matches a valid queued entry.
- rs2_pending  out  1  q_rs2 is nonzero and matches a valid queued entry.
- rd_pending  out  1  q_rd is nonzero and matches a valid queued entry.
- starve_stall  out  1  request to the pipeline to withhold writebacks so the queue can drain.

Behaviour:
Reset
- resetn low, asynchronously: count, read pointer, write pointer and starve counter go to 0; queue contents become invalid.
- Outputs while resetn is low: rf_we=0, rf_a3=0, rf_wd=0, pending flags=0, starve_stall=0, ll_ready=0.
- After release: ll_ready=1.
- Reset mid-operation discards queued results; nothing is written.

Write-port selection (combinational, same cycle)
- Pipeline write is effective when pipe_we=1 and pipe_rd!=0.
  - If effective: rf_we=1, rf_a3=pipe_rd, rf_wd=pipe_wd; the queue does not pop.
- Otherwise, if count>0: rf_we=1, rf_a3=head.rd, rf_wd=head.wd; pop at the clock edge.
- Otherwise rf_we=0, and rf_a3/rf_wd=0.
- A pipeline write to x0 counts as idle and lets the queue drain.

Queue
- ll_ready = (count < QUEUE_DEPTH), from registered state only; no same-cycle pop-through.
- Accept with ll_rd=0: handshake completes, no entry is enqueued.
- Accept with nonzero ll_rd: enqueue {ll_rd, ll_wd} at the tail.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH.
- There is no bypass from ll input to rf; minimum latency from accept to rf_we is 1 cycle.
- Entries drain strictly in FIFO order.

Pending flags
- Combinational compare of q_* against all valid entries, from registered state.
- An accept in the current cycle is not reflected until the next cycle.
- The entry being popped this cycle still reports pending this cycle (conservative).
- Ordering correctness relies on the hazard unit stalling on rd_pending. The arbiter does not reorder same-rd writes.

Starvation
- Counter increments when count>0 and an effective pipeline write occurs.
- Counter clears on any pop or when count=0.
- Counter saturates at STARVE_LIMIT.
- starve_stall = (counter == STARVE_LIMIT), registered.
- It deasserts in the cycle after the pop edge.

Decomposition:
- Package wb_pkg:
  - typedef wb_entry_t {logic [4:0] rd; logic [31:0] wd;}
  - localparam REG_ADDR_W=5, XLEN=32.
- Sub-module wb_queue: synchronous FIFO of wb_entry_t.
  - Asynchronous active-low reset.
  - Three address-match query ports.
  - Exports head, count, full, empty.
- The arbiter adds port selection and the starve counter.

Test Plan:
- Reset drive: hold resetn=0 with ll_valid=1 -> rf_we=0, ll_ready=0, all pending=0; after release, ll_ready=1 within 0 cycles.
- Idle drain: accept ll_rd=5, ll_wd=0xDEADBEEF with pipe_we=0.
  - Next cycle: rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; rd_pending(q_rd=5)=1 that cycle, 0 the cycle after.
- Priority/full: pipe_we=1, pipe_rd=3 every cycle; accept ll entries rd=7 and rd=8.
  - ll_ready=0 after 2 accepts; rf_a3 stays 3.
  - starve_stall=1 after 4 blocked cycles.
  - Drop pipe_we -> rd 7 then rd 8 are written in order.
- x0 filtering: accept ll_rd=0 -> count stays 0, no rf_we. pipe_we=1, pipe_rd=0 with queue holding rd=9 -> rf_a3=9 is written.
- Simultaneous push/pop at full: queue full, pipe idle, ll_valid=1 -> ll_ready=0 that cycle; next cycle ll_ready=1, accept and pop together, count stays 1 and order is preserved.
- Mid-operation reset: queue holds 2 entries, pulse resetn low for 1 cycle -> no rf_we follows, pending=0, count=0.
